// File: rtl/microcode_sequencer_pkg.sv
// Shared types and control-word field positions for the micro-program sequencer.
// The cond_sel width depends on COND_N, so the escape bit position is derived in the top.
package pa_useq;

    typedef enum logic [1:0] {
        STEP   = 2'd0,
        BRANCH = 2'd1,
        FETCH  = 2'd2,
        TRAP   = 2'd3
    } typ_e;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } seq_state_e;

    localparam int TYP_LSB      = 0;
    localparam int OFF_LSB      = 2;
    localparam int COND_INV_POS = 9;
    localparam int COND_SEL_LSB = 11;

endpackage

// File: rtl/microcode_sequencer_next_addr.sv
// Combinational next-uPC selection from the decoded sequencing fields of the current word.
// Also flags whether a FETCH word takes the interrupt or enters halt.
module useq_next_addr
    import pa_useq::*;
#(
    parameter int UADDR_W   = 14,
    parameter int OFF_W     = 7,
    parameter int COND_N    = 16,
    parameter int IR_W      = 8,
    parameter int OP_SLOT_W = 6,
    parameter int RESET_VEC = 0,
    parameter int IRQ_VEC   = 16,
    localparam int SEL_W    = (COND_N > 1) ? $clog2(COND_N) : 1
) (
    input  typ_e               typ,
    input  logic [OFF_W-1:0]   u_offset,
    input  logic               cond_invert,
    input  logic [SEL_W-1:0]   cond_sel,
    input  logic               escape,
    input  logic [UADDR_W-1:0] upc,
    input  logic [IR_W-1:0]    ir,
    input  logic [COND_N-1:0]  cond_in,
    input  logic               irq_req,
    input  logic               irq_en,
    input  logic               halt_req,
    output logic [UADDR_W-1:0] next_upc,
    output logic               take_irq,
    output logic               enter_halt
);

    logic [UADDR_W-1:0] off_ext;
    logic [UADDR_W-1:0] disp;
    logic               cond_hit;

    // Width casts do the sign extension of the offset and the truncation of the dispatch address.
    assign off_ext  = UADDR_W'($signed(u_offset));
    assign disp     = UADDR_W'({escape, ir, {OP_SLOT_W{1'b0}}});
    assign cond_hit = cond_in[cond_sel] ^ cond_invert;

    always_comb begin
        next_upc   = upc + UADDR_W'(1);
        take_irq   = 1'b0;
        enter_halt = 1'b0;
        unique case (typ)
            STEP: begin
                if (u_offset != '0) begin
                    next_upc = upc + off_ext;
                end
            end
            BRANCH: begin
                if (cond_hit) begin
                    next_upc = upc + off_ext;
                end
            end
            FETCH: begin
                // Interrupt beats halt, halt beats dispatch; a halting word keeps the uPC frozen.
                if (irq_req && irq_en) begin
                    next_upc = UADDR_W'(IRQ_VEC);
                    take_irq = 1'b1;
                end else if (halt_req) begin
                    next_upc   = upc;
                    enter_halt = 1'b1;
                end else begin
                    next_upc = disp;
                end
            end
            TRAP: begin
                next_upc = UADDR_W'(RESET_VEC);
            end
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Micro-program sequencer: owns the uPC, addresses the synchronous microcode ROM and
// forwards executable control words, with stall, halt and interrupt entry handling.
module microcode_sequencer
    import pa_useq::*;
#(
    parameter int CW_BYTES  = 14,
    parameter int UADDR_W   = 14,
    parameter int OFF_W     = 7,
    parameter int COND_N    = 16,
    parameter int IR_W      = 8,
    parameter int OP_SLOT_W = 6,
    parameter int RESET_VEC = 0,
    parameter int IRQ_VEC   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [UADDR_W-1:0]    rom_addr,
    input  logic [8*CW_BYTES-1:0] rom_data,
    output logic [8*CW_BYTES-1:0] cw_out,
    output logic                  cw_valid,
    input  logic [IR_W-1:0]       ir,
    input  logic [COND_N-1:0]     cond_in,
    input  logic                  stall,
    input  logic                  halt_req,
    input  logic                  irq_req,
    input  logic                  irq_en,
    output logic                  irq_taken,
    output logic [1:0]            seq_state
);

    localparam int SEL_W   = (COND_N > 1) ? $clog2(COND_N) : 1;
    localparam int ESC_POS = COND_SEL_LSB + SEL_W;

    seq_state_e         state;
    logic [UADDR_W-1:0] upc;
    logic [UADDR_W-1:0] next_upc;
    logic               take_irq;
    logic               enter_halt;

    useq_next_addr #(
        .UADDR_W   (UADDR_W),
        .OFF_W     (OFF_W),
        .COND_N    (COND_N),
        .IR_W      (IR_W),
        .OP_SLOT_W (OP_SLOT_W),
        .RESET_VEC (RESET_VEC),
        .IRQ_VEC   (IRQ_VEC)
    ) u_next_addr (
        .typ         (typ_e'(rom_data[TYP_LSB +: 2])),
        .u_offset    (rom_data[OFF_LSB +: OFF_W]),
        .cond_invert (rom_data[COND_INV_POS]),
        .cond_sel    (rom_data[COND_SEL_LSB +: SEL_W]),
        .escape      (rom_data[ESC_POS]),
        .upc         (upc),
        .ir          (ir),
        .cond_in     (cond_in),
        .irq_req     (irq_req),
        .irq_en      (irq_en),
        .halt_req    (halt_req),
        .next_upc    (next_upc),
        .take_irq    (take_irq),
        .enter_halt  (enter_halt)
    );

    // The ROM is addressed with the uPC it will hold next, so its data lines up with the uPC.
    always_comb begin
        rom_addr = upc;
        case (state)
            S_RUN:   rom_addr = stall ? upc : next_upc;
            S_HALT:  rom_addr = UADDR_W'(IRQ_VEC);
            default: rom_addr = upc;
        endcase
    end

    assign cw_valid  = (state == S_RUN) && !stall;
    assign cw_out    = cw_valid ? rom_data : '0;
    assign seq_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PRIME;
            upc       <= UADDR_W'(RESET_VEC);
            irq_taken <= 1'b0;
        end else begin
            irq_taken <= 1'b0;
            unique case (state)
                S_PRIME: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (stall) begin
                        state <= S_STALL;
                    end else begin
                        upc <= next_upc;
                        if (take_irq) begin
                            irq_taken <= 1'b1;
                        end
                        if (enter_halt) begin
                            state <= S_HALT;
                        end
                    end
                end
                S_STALL: begin
                    if (!stall) begin
                        state <= S_RUN;
                    end
                end
                S_HALT: begin
                    // Waking passes through S_PRIME so the ROM has a cycle to fetch the entry word.
                    if (irq_req && irq_en) begin
                        state     <= S_PRIME;
                        upc       <= UADDR_W'(IRQ_VEC);
                        irq_taken <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed table-driven bench for microcode_sequencer; the bench plays the ROM by
// presenting, each cycle, the control word stored at the current uPC.
module tb_microcode_sequencer;
    import pa_useq::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [13:0]  rom_addr;
    logic [111:0] rom_data = '0;
    logic [111:0] cw_out;
    logic         cw_valid;
    logic [7:0]   ir = '0;
    logic [15:0]  cond_in = '0;
    logic         stall = 1'b0;
    logic         halt_req = 1'b0;
    logic         irq_req = 1'b0;
    logic         irq_en = 1'b0;
    logic         irq_taken;
    logic [1:0]   seq_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [111:0] word;
        logic [7:0]   ir;
        logic [15:0]  cond;
        logic         stall;
        logic         halt;
        logic         irq;
        logic         irq_en;
        logic [13:0]  exp_addr;
        logic         chk_addr;
        logic         exp_valid;
        logic [1:0]   exp_state;
        logic         exp_irq_taken;
    } vec_t;

    vec_t vecs[$];

    microcode_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cw_out    (cw_out),
        .cw_valid  (cw_valid),
        .ir        (ir),
        .cond_in   (cond_in),
        .stall     (stall),
        .halt_req  (halt_req),
        .irq_req   (irq_req),
        .irq_en    (irq_en),
        .irq_taken (irq_taken),
        .seq_state (seq_state)
    );

    always #5 clk = ~clk;

    function automatic logic [111:0] mkw(input logic [1:0] typ, input int off, input logic inv,
                                         input logic [3:0] sel, input logic esc);
        logic [111:0] w;
        logic [31:0]  off32;
        off32    = off;
        w        = {$urandom, $urandom, $urandom, 16'h0000};
        w[1:0]   = typ;
        w[8:2]   = off32[6:0];
        w[9]     = inv;
        w[10]    = 1'b0;
        w[14:11] = sel;
        w[15]    = esc;
        return w;
    endfunction

    function automatic vec_t mkv(input logic [111:0] word, input logic [7:0] vir,
                                 input logic [15:0] cond, input logic vstall, input logic vhalt,
                                 input logic virq, input logic ven, input logic [13:0] ea,
                                 input logic ca, input logic ev, input logic [1:0] es,
                                 input logic eit);
        vec_t v;
        v.word = word; v.ir = vir; v.cond = cond; v.stall = vstall; v.halt = vhalt;
        v.irq = virq; v.irq_en = ven; v.exp_addr = ea; v.chk_addr = ca;
        v.exp_valid = ev; v.exp_state = es; v.exp_irq_taken = eit;
        return v;
    endfunction

    task automatic cmp(input string tag, input string name, input logic [111:0] got,
                       input logic [111:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s %s got %h want %h", tag, name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rom_data = v.word;
        ir       = v.ir;
        cond_in  = v.cond;
        stall    = v.stall;
        halt_req = v.halt;
        irq_req  = v.irq;
        irq_en   = v.irq_en;
        #2;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        if (v.chk_addr) cmp(tag, "rom_addr", 112'(rom_addr), 112'(v.exp_addr));
        cmp(tag, "cw_valid", 112'(cw_valid), 112'(v.exp_valid));
        cmp(tag, "seq_state", 112'(seq_state), 112'(v.exp_state));
        cmp(tag, "irq_taken", 112'(irq_taken), 112'(v.exp_irq_taken));
        cmp(tag, "cw_out", cw_out, v.exp_valid ? v.word : 112'd0);
    endtask

    initial begin
        vec_t v;
        localparam logic [1:0] PR = 2'(S_PRIME);
        localparam logic [1:0] RU = 2'(S_RUN);
        localparam logic [1:0] ST = 2'(S_STALL);
        localparam logic [1:0] HA = 2'(S_HALT);

        // word, ir, cond, stall, halt, irq, irq_en, exp_addr, chk_addr, exp_valid, exp_state, exp_irq_taken
        vecs.push_back(mkv('0, 8'h00, 16'h0000, 1, 0, 0, 0, 14'h0000, 1, 0, PR, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0001, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0002, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0003, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 2, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0005, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(BRANCH, -3, 0, 4, 0), 8'h00, 16'h0010, 0, 0, 0, 0, 14'h0002, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 3, 0, 0, 0), 8'h00, 16'h0010, 0, 0, 0, 0, 14'h0005, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(BRANCH, -3, 1, 4, 0), 8'h00, 16'h0010, 0, 0, 0, 0, 14'h0006, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(BRANCH, 3, 0, 7, 0), 8'h00, 16'h0010, 0, 0, 0, 0, 14'h0007, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(BRANCH, 2, 1, 7, 0), 8'h00, 16'h0010, 0, 0, 0, 0, 14'h0009, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 1, 0, 0, 0, 14'h0009, 1, 0, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 1, 0, 0, 0, 14'h0009, 1, 0, ST, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 1, 0, 0, 0, 14'h0009, 1, 0, ST, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0009, 1, 0, ST, 0));
        vecs.push_back(mkv(mkw(FETCH, 0, 0, 0, 1), 8'h2A, 16'h0000, 0, 0, 0, 0, 14'h0A80, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(FETCH, 0, 0, 0, 0), 8'hAA, 16'h0000, 0, 0, 0, 0, 14'h2A80, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(FETCH, 0, 0, 0, 0), 8'hAA, 16'h0000, 0, 1, 1, 1, 14'h0010, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 1, 1, 14'h0011, 1, 1, RU, 1));
        vecs.push_back(mkv(mkw(FETCH, 0, 0, 0, 0), 8'h01, 16'h0000, 0, 0, 1, 0, 14'h0040, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(TRAP, 5, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(FETCH, 0, 0, 0, 0), 8'h33, 16'h0000, 0, 1, 0, 0, 14'h0000, 0, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h33, 16'h0000, 1, 1, 0, 0, 14'h0010, 1, 0, HA, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h33, 16'h0000, 0, 0, 1, 0, 14'h0010, 1, 0, HA, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h33, 16'h0000, 0, 0, 1, 1, 14'h0010, 1, 0, HA, 0));
        vecs.push_back(mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 1, 0, 0, 0, 14'h0010, 1, 0, PR, 1));
        vecs.push_back(mkv(mkw(STEP, -17, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h3FFF, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, 1, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 1, RU, 0));
        vecs.push_back(mkv(mkw(STEP, -1, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h3FFF, 1, 1, RU, 0));

        v = mkv('0, 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 0, PR, 0);
        applyStimulus(v);
        checkOutput(v, "reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset landing in the middle of a BRANCH cycle at the top of the address space.
        v = mkv(mkw(BRANCH, 2, 1, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0001, 1, 1, RU, 0);
        applyStimulus(v);
        checkOutput(v, "pre_reset");
        #1 rst_n = 1'b0;
        #1;
        v = mkv(v.word, 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 0, PR, 0);
        checkOutput(v, "mid_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        v = mkv('0, 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 0, PR, 0);
        applyStimulus(v);
        checkOutput(v, "post_prime");
        v = mkv(mkw(STEP, -1, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h3FFF, 1, 1, RU, 0);
        applyStimulus(v);
        checkOutput(v, "wrap_down");
        v = mkv(mkw(STEP, 1, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0000, 1, 1, RU, 0);
        applyStimulus(v);
        checkOutput(v, "wrap_up");
        v = mkv(mkw(STEP, 0, 0, 0, 0), 8'h00, 16'h0000, 0, 0, 0, 0, 14'h0001, 1, 1, RU, 0);
        applyStimulus(v);
        checkOutput(v, "after_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
